// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared types for the bit-serial adder (FSM state encoding).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_full_adder_cell.sv
// ============================================================================
// Module  : full_adder_cell
// Brief   : 1-bit combinational full adder used as the serial datapath bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   shift_a_q, shift_a_d;
    logic [WIDTH-1:0]   shift_b_q, shift_b_d;
    logic [WIDTH-1:0]   part_q,    part_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               carry_q,   carry_d;
    logic               c_msb_q,   c_msb_d;
    logic               cout_q,    cout_d;
    logic               ovf_q,     ovf_d;

    logic               fa_s;
    logic               fa_c;

    full_adder_cell u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        part_d    = part_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        c_msb_d   = c_msb_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start too, so back-to-back operations lose no cycle.
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                    part_d    = '0;
                    c_msb_d   = 1'b0;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                part_d    = {fa_s, part_q[WIDTH-1:1]};
                carry_d   = fa_c;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_PEN) begin
                    c_msb_d = fa_c;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, part_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = c_msb_q ^ fa_c;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            part_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            c_msb_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            part_q    <= part_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            c_msb_q   <= c_msb_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Directed vector bench for serial_adder (WIDTH = 8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives start for one edge; returns at the negedge just after acceptance.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] prev_sum;

        vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hC0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum",  sum,  0);
        check("reset cout", cout, 0);
        check("reset ovf",  ovf,  0);

        prev_sum = 8'h00;
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("v%0d busy", i), busy, 1);
            check($sformatf("v%0d hold sum", i), sum, prev_sum);
            wait_done(lat);
            check($sformatf("v%0d latency", i), lat, WIDTH);
            check($sformatf("v%0d busy at done", i), busy, 0);
            check($sformatf("v%0d sum", i), sum, vecs[i].sum);
            check($sformatf("v%0d cout", i), cout, vecs[i].cout);
            check($sformatf("v%0d ovf", i), ovf, vecs[i].ovf);
            @(negedge clk);
            check($sformatf("v%0d done pulse", i), done, 0);
            prev_sum = vecs[i].sum;
            @(negedge clk);
        end

        // Start during RUN must be ignored.
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        wait_done(lat);
        lat = lat + 3;
        check("ignore latency", lat, WIDTH);
        check("ignore sum", sum, 8'h30);
        watch_no_done("ignore second done", 12);

        // Back-to-back: new start accepted in the DONE cycle.
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(lat);
        check("b2b first latency", lat, WIDTH);
        check("b2b first sum", sum, 8'h03);
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h04;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        check("b2b busy", busy, 1);
        wait_done(lat);
        check("b2b second latency", lat, WIDTH);
        check("b2b second sum", sum, 8'h07);
        @(negedge clk);

        // Reset mid-RUN abandons the operation.
        start_op(8'h55, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst sum",  sum,  0);
        check("midrst cout", cout, 0);
        check("midrst ovf",  ovf,  0);
        watch_no_done("midrst no done", 12);
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(lat);
        check("post-rst latency", lat, WIDTH);
        check("post-rst sum", sum, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: latches two operands and a carry-in on a start handshake.
- Adds LSB-first through one full-adder cell and a carry flop, one bit per clock.
- Reports sum, carry-out and signed overflow after WIDTH cycles.
- Arithmetic counterpart to the team's subtractor cells; used where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH), width of internal bit counter (derived, not overridden)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request: latch a, b, cin and begin addition
a      input   WIDTH  operand A, sampled only on accepted start
b      input   WIDTH  operand B, sampled only on accepted start
cin    input   1      carry-in, sampled only on accepted start
busy   output  1      high while addition in progress (RUN state)
done   output  1      one-cycle pulse: result registers just updated
sum    output  WIDTH  registered result a+b+cin mod 2^WIDTH
cout   output  1      registered carry out of MSB
ovf    output  1      registered signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift regs, counter and carry flop=0. Reset takes priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> load shift_a=a, shift_b=b, carry=cin, cnt=0, clear partial reg; go to RUN. start=0 -> stay.
- RUN (busy=1):
  - Each cycle: s = shift_a[0]^shift_b[0]^carry; c = majority(shift_a[0], shift_b[0], carry).
  - s shifts into partial-sum MSB (right shift); shift_a/shift_b shift right; carry<=c; cnt++.
  - On cnt==WIDTH-2, also record carry into MSB (c) for ovf.
  - On cnt==WIDTH-1: write sum<=final partial, cout<=c, ovf<=c_into_msb^c; go to DONE.
- DONE: done=1 for exactly this cycle; busy=0.
  - start=1 -> accept as in IDLE and go to RUN (back-to-back supported).
  - Otherwise -> IDLE.
- Latency: start accepted on edge T -> done high during cycle T+WIDTH; result visible from that same edge.
- sum/cout/ovf change only on the completion edge; they hold the previous result through RUN and IDLE until the next completion.
- start during RUN: ignored; operands are not resampled and the current operation is unaffected.
- a/b/cin changing while not accepting start: no effect.
- Reset mid-RUN: operation abandoned; no done pulse; outputs return to reset values.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Decomposition:
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE) and the state encoding width constant.
- One sub-module, full_adder_cell: 1-bit combinational full adder (a, b, cin -> s, cout), instantiated once for the datapath bit.
- Counter, shifters and FSM live in serial_adder.

Test Plan (WIDTH=8):
1. a=0x35, b=0x1A, cin=0, start one cycle -> busy for 8 cycles; done pulse at T+8; sum=0x4F, cout=0, ovf=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
3. a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
4. Start 0x10+0x20; pulse start with a=0xAA, b=0x55 at cycle T+3 -> ignored; sum=0x30 at T+8; no second done pulse.
5. Start 0x01+0x02; assert start with 0x03+0x04 in the DONE cycle -> first done gives sum=0x03; second done exactly 8 cycles later gives sum=0x07.
6. Start 0x55+0x55; assert rst at T+4 for one cycle -> no done pulse; busy=0, sum=0, cout=0, ovf=0; a following start 0x01+0x01 yields sum=0x02.
